// File: rtl/fc_sched_if.sv
// Handshake bundle for fc_sched: ibuf write/backpressure, per-phase start/busy
// pairs, next-layer backpressure and status/clear.
interface fc_sched_if;
  logic ibuf_we;
  logic busy;
  logic ctrl_start;
  logic ctrl_busy;
  logic cim_start;
  logic cim_busy;
  logic func_start;
  logic func_busy;
  logic next_busy;
  logic layer_done;
  logic error;
  logic overflow;
  logic clr_err;

  // Scheduler side
  modport master (
    input  ibuf_we, ctrl_busy, cim_busy, func_busy, next_busy, clr_err,
    output busy, ctrl_start, cim_start, func_start, layer_done, error, overflow
  );

  // Surrounding layer / phase engines
  modport slave (
    output ibuf_we, ctrl_busy, cim_busy, func_busy, next_busy, clr_err,
    input  busy, ctrl_start, cim_start, func_start, layer_done, error, overflow
  );
endinterface

// File: rtl/fc_sched.sv
// Fully-connected layer sequencer: counts ibuf writes, then runs ctrl load, CIM
// compute and func readout with start/busy handshakes. FC_SCHED_OVERLAP_EN lets
// the ibuf refill once ctrl load is done.
module fc_sched #(
  parameter int unsigned INPUT_SIZE  = 201,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  fc_sched_if.master bus
);

  localparam int unsigned CNT_W = $clog2(INPUT_SIZE + 1);
  localparam int unsigned ACK_W = 8;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(INPUT_SIZE);
  localparam logic [ACK_W-1:0] ACK_LIMIT = ACK_W'(ACK_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, LOAD_ACK, LOAD_RUN, CIM_ACK, CIM_RUN,
    FUNC_WAIT, FUNC_ACK, FUNC_RUN, ERR
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACK_W-1:0] ack_cnt, ack_nxt, ack_inc;
  logic             busy_q, busy_nxt;
  logic             ctrl_start_q, ctrl_start_nxt;
  logic             cim_start_q, cim_start_nxt;
  logic             func_start_q, func_start_nxt;
  logic             done_q, done_nxt;
  logic             error_q, error_nxt;
  logic             ovf_q, ovf_nxt;
  logic             accept;
  logic             pulse_cycle;
  logic             ack_busy;

  function automatic logic is_ack(state_t s);
    return (s == LOAD_ACK) || (s == CIM_ACK) || (s == FUNC_ACK);
  endfunction

  function automatic state_t run_of(state_t s);
    case (s)
      LOAD_ACK: return LOAD_RUN;
      CIM_ACK:  return CIM_RUN;
      default:  return FUNC_RUN;
    endcase
  endfunction

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ack_cnt      <= '0;
      busy_q       <= 1'b0;
      ctrl_start_q <= 1'b0;
      cim_start_q  <= 1'b0;
      func_start_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ack_cnt      <= ack_nxt;
      busy_q       <= busy_nxt;
      ctrl_start_q <= ctrl_start_nxt;
      cim_start_q  <= cim_start_nxt;
      func_start_q <= func_start_nxt;
      done_q       <= done_nxt;
      error_q      <= error_nxt;
      ovf_q        <= ovf_nxt;
    end
  end

  // Next-state, input count, ack timer and registered output values
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ack_nxt        = ack_cnt;
    ack_inc        = ack_cnt + ACK_W'(1);
    done_nxt       = 1'b0;
    error_nxt      = error_q;
    ovf_nxt        = ovf_q;
    busy_nxt       = 1'b0;
    ctrl_start_nxt = 1'b0;
    cim_start_nxt  = 1'b0;
    func_start_nxt = 1'b0;
    accept         = bus.ibuf_we & ~busy_q;
    pulse_cycle    = ctrl_start_q | cim_start_q | func_start_q;
    ack_busy       = 1'b0;

    case (state)
      LOAD_ACK: ack_busy = bus.ctrl_busy;
      CIM_ACK:  ack_busy = bus.cim_busy;
      FUNC_ACK: ack_busy = bus.func_busy;
      default:  ack_busy = 1'b0;
    endcase

    if (accept && (cnt != CNT_FULL)) cnt_nxt = cnt + CNT_W'(1);
    if (bus.ibuf_we && busy_q) ovf_nxt = 1'b1;

    case (state)
      IDLE: begin
        if ((cnt == CNT_FULL) && !error_q) state_nxt = LOAD_ACK;
      end
      LOAD_ACK, CIM_ACK, FUNC_ACK: begin
        // Busy on the pulse cycle is left over from before the start; ignore it.
        if (!pulse_cycle) begin
          if (ack_busy) begin
            state_nxt = run_of(state);
          end else begin
            ack_nxt = ack_inc;
            if (ack_inc == ACK_LIMIT) state_nxt = ERR;
          end
        end
      end
      LOAD_RUN: begin
        if (!bus.ctrl_busy) begin
          state_nxt = CIM_ACK;
          cnt_nxt   = accept ? CNT_W'(1) : '0;
        end
      end
      CIM_RUN: begin
        if (!bus.cim_busy) state_nxt = bus.next_busy ? FUNC_WAIT : FUNC_ACK;
      end
      FUNC_WAIT: begin
        if (!bus.next_busy) state_nxt = FUNC_ACK;
      end
      FUNC_RUN: begin
        if (!bus.func_busy) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == ERR) error_nxt = 1'b1;
    if (is_ack(state_nxt) && (state_nxt != state)) ack_nxt = '0;

    // Clear wins over every transition taken above
    if (bus.clr_err) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      ack_nxt   = '0;
      done_nxt  = 1'b0;
      error_nxt = 1'b0;
      ovf_nxt   = 1'b0;
    end

    ctrl_start_nxt = (state_nxt == LOAD_ACK) && (state != LOAD_ACK);
    cim_start_nxt  = (state_nxt == CIM_ACK)  && (state != CIM_ACK);
    func_start_nxt = (state_nxt == FUNC_ACK) && (state != FUNC_ACK);

`ifdef FC_SCHED_OVERLAP_EN
    busy_nxt = error_nxt | (cnt_nxt == CNT_FULL);
`else
    busy_nxt = error_nxt | (cnt_nxt == CNT_FULL) | (state_nxt != IDLE) | done_nxt;
`endif
  end

  assign bus.busy       = busy_q;
  assign bus.ctrl_start = ctrl_start_q;
  assign bus.cim_start  = cim_start_q;
  assign bus.func_start = func_start_q;
  assign bus.layer_done = done_q;
  assign bus.error      = error_q;
  assign bus.overflow   = ovf_q;

endmodule
